pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register, replacing fixed per-stage latches (F/D, D/X, X/M, M/W).
//  Carries NFIELDS packed fields of WIDTH bits and uses valid/ready flow control instead of a bare enable.
//  Optionally includes a skid buffer so in_ready is registered.
//  Flush inserts a NOP bubble. A saturating counter records bubble cycles for performance analysis.
// PARAMETERS
//  WIDTH     32     bits per field
//  NFIELDS   5      number of fields (e.g. PC, PC1, IR, O, B)
//  IR_FIELD  2      index of the instruction field that receives NOP on reset/flush
//  NOP       32'h0  bubble instruction pattern, WIDTH bits
//  SKID      1      1 = 2-entry skid buffer (registered in_ready); 0 = single register
//  CNT_W     16     bubble counter width
// PORTS
//  clk           in   1               rising-edge clock
//  reset         in   1               synchronous, active-low; reset==0 at a clk edge resets
//  flush         in   1               synchronous squash of all held entries
//  in_valid      in   1               upstream has data
//  in_ready      out  1               stage accepts data this cycle
//  in_data       in   NFIELDS*WIDTH   field k = in_data[k*WIDTH +: WIDTH]
//  out_valid     out  1               out_data is valid
//  out_ready     in   1               downstream accepts this cycle
//  out_data      out  NFIELDS*WIDTH   registered output fields
//  occupancy     out  2               entries held: 0, 1 or 2
//  bubble_cnt    out  CNT_W           cycles with out_ready=1 and out_valid=0, saturating
// BEHAVIOUR
//  in_fire  = in_valid & in_ready.  out_fire = out_valid & out_ready.  All state updates on posedge clk.
//  Reset (reset==0):
//   - state=EMPTY, out_valid=0, occupancy=0, bubble_cnt=0
//   - out_data: all fields 0 except IR_FIELD=NOP; skid entry cleared
//   - in_ready=1 in the first cycle after reset
//   - reset overrides flush and all handshakes.
//  Flush (reset==1, flush==1):
//   - same data effect as reset: EMPTY, out_valid=0, out_data = bubble pattern
//   - bubble_cnt is NOT cleared
//   - an in_fire in the same cycle is discarded
//   - out_fire in the same cycle still counts as consumed by downstream.
//  SKID=1 FSM (in_ready registered, in_ready = state!=FULL2):
//   EMPTY: in_fire -> FULL1, main<=in_data
//   FULL1:
//    - in_fire & out_fire -> FULL1, main<=in_data
//    - in_fire & !out_fire -> FULL2, skid<=in_data
//    - !in_fire & out_fire -> EMPTY (main holds stale value)
//    - else hold
//   FULL2: out_fire -> FULL1, main<=skid; else hold. No input accepted in FULL2.
//  SKID=0: one register; in_ready = out_ready | ~out_valid (combinational); occupancy max 1.
//   - in_fire -> main<=in_data, out_valid=1
//   - out_fire & !in_fire -> out_valid=0
//  out_valid = (state!=EMPTY); occupancy = 0/1/2 for EMPTY/FULL1/FULL2.
//  out_data is stable while out_valid & !out_ready (no change without out_fire).
//  Ordering is strict FIFO; no entry is dropped or duplicated except by flush.
//  Latency: in_fire at edge N -> out_valid=1 after edge N (1 cycle) when stage empty.
//  bubble_cnt: +1 each cycle with out_ready & !out_valid; holds at 2^CNT_W-1.
// TESTING
//  1 reset=0 for 2 cycles with in_valid=1 -> out_valid=0, IR field=NOP, occupancy=0, in_ready=1 after release.
//  2 Streaming: in_valid=1 and out_ready=1 for 8 cycles, data 1..8 -> out_data 1..8 in order, 1-cycle latency, occupancy stays 1.
//  3 Backpressure (SKID=1): out_ready=0 while sending A,B -> occupancy=2, in_ready=0, C held upstream.
//    Then out_ready=1 -> outputs A,B,C in order.
//  4 Flush with occupancy=2 and in_valid=1 -> next cycle out_valid=0, IR=NOP, occupancy=0; input dropped.
//  5 out_ready=1, in_valid=0 for 70000 cycles with CNT_W=16 -> bubble_cnt=16'hFFFF, no wrap.
//  6 SKID=0 build, run scenarios 2-4 -> in_ready tracks out_ready|~out_valid combinationally, occupancy never 2.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control, optional 2-entry skid
// buffer, flush-to-bubble and a saturating bubble-cycle counter.
module pipe_stage_reg #(
  parameter int               WIDTH    = 32,
  parameter int               NFIELDS  = 5,
  parameter int               IR_FIELD = 2,
  parameter logic [WIDTH-1:0] NOP      = '0,
  parameter bit               SKID     = 1'b1,
  parameter int               CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NFIELDS*WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NFIELDS*WIDTH-1:0] out_data,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam int DW = NFIELDS * WIDTH;
  localparam logic [DW-1:0] BUBBLE = DW'(NOP) << (IR_FIELD * WIDTH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [DW-1:0]   main_q, skid_q;
  logic            in_fire, out_fire;
  logic            load_main_in, load_main_skid, load_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  // FULL2 is only reachable with the skid buffer; without it in_ready already implies out_fire.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_next   = FULL1;
          load_main_in = 1'b1;
        end
      end
      FULL1: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          if (SKID) begin
            state_next = FULL2;
            load_skid  = 1'b1;
          end else begin
            load_main_in = 1'b1;
          end
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL2: begin
        if (out_fire) begin
          state_next     = FULL1;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_comb begin
    out_valid = (state != EMPTY);
    occupancy = state;
    out_data  = main_q;
    if (SKID) in_ready = (state != FULL2);
    else      in_ready = out_ready | ~out_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      main_q <= BUBBLE;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
